// File: rtl/if_pkg.sv
// Shared types and defaults for the if-then-else dispatch controller.
package if_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefTmo   = 255;

  typedef enum logic [2:0] {
    StIdle,
    StPGo,
    StPWait,
    StBGo,
    StBWait
  } state_e;

endpackage

// File: rtl/if_watchdog.sv
// Wait-state cycle counter; o_expired is high during the TMO-th cycle of an enabled run.
module if_watchdog #(
  parameter int unsigned TMO = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = (TMO > 2) ? $clog2(TMO) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == CW'(TMO - 1));

endmodule

// File: rtl/if_dispatch.sv
// If-then-else controller: runs the predicate block, then exactly one branch block.
// Define IF_DISPATCH_TIMEOUT_EN to add the ERR port and the wait-state watchdog.
module if_dispatch
  import if_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned TMO   = DefTmo
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  output logic             RD,
  output logic [WIDTH-1:0] RES,
`ifdef IF_DISPATCH_TIMEOUT_EN
  output logic             ERR,
`endif
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [WIDTH-1:0] IN3,
  output logic [WIDTH-1:0] OP1,
  output logic [WIDTH-1:0] OP2,
  output logic [WIDTH-1:0] OP3,
  output logic             P_ST,
  input  logic             P_RD,
  input  logic [WIDTH-1:0] P_RES,
  output logic             Y_ST,
  input  logic             Y_RD,
  input  logic [WIDTH-1:0] Y_RES,
  output logic             N_ST,
  input  logic             N_RD,
  input  logic [WIDTH-1:0] N_RES
);

  if (TMO < 2) begin : g_tmo_bad
    $error("if_dispatch: TMO must be at least 2");
  end

  state_e           r_state, w_state_d;
  logic             r_rd, w_rd_d;
  logic [WIDTH-1:0] r_res, w_res_d;
  logic [WIDTH-1:0] r_op1, r_op2, r_op3, w_op1_d, w_op2_d, w_op3_d;
  logic             r_sel, w_sel_d;
  logic             r_p_st, r_y_st, r_n_st, w_p_st_d, w_y_st_d, w_n_st_d;
  logic             w_pred_true, w_br_rd;
  logic [WIDTH-1:0] w_br_res;

  assign w_pred_true = |P_RES;
  // Only the selected branch's handshake is ever looked at.
  assign w_br_rd     = r_sel ? Y_RD : N_RD;
  assign w_br_res    = r_sel ? Y_RES : N_RES;

`ifdef IF_DISPATCH_TIMEOUT_EN
  logic r_err, w_err_d;
  logic w_wd_clr, w_wd_en, w_wd_exp;

  if_watchdog #(
    .TMO(TMO)
  ) u_watchdog (
    .i_clk    (CLK),
    .i_rst_n  (RST),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expired(w_wd_exp)
  );

  assign ERR      = r_err;
  assign w_wd_clr = (r_state == StPGo) || (r_state == StBGo);
  assign w_wd_en  = (r_state == StPWait) || (r_state == StBWait);
`endif

  always_comb begin
    w_state_d = r_state;
    w_rd_d    = r_rd;
    w_res_d   = r_res;
    w_op1_d   = r_op1;
    w_op2_d   = r_op2;
    w_op3_d   = r_op3;
    w_sel_d   = r_sel;
    w_p_st_d  = 1'b0;
    w_y_st_d  = 1'b0;
    w_n_st_d  = 1'b0;
`ifdef IF_DISPATCH_TIMEOUT_EN
    w_err_d   = r_err;
`endif
    unique case (r_state)
      StIdle: begin
        if (ST) begin
          w_op1_d   = IN1;
          w_op2_d   = IN2;
          w_op3_d   = IN3;
          w_rd_d    = 1'b0;
          w_p_st_d  = 1'b1;
          w_state_d = StPGo;
`ifdef IF_DISPATCH_TIMEOUT_EN
          w_err_d   = 1'b0;
`endif
        end
      end
      StPGo: w_state_d = StPWait;
      StPWait: begin
        if (P_RD) begin
          w_sel_d   = w_pred_true;
          w_y_st_d  = w_pred_true;
          w_n_st_d  = !w_pred_true;
          w_state_d = StBGo;
        end
`ifdef IF_DISPATCH_TIMEOUT_EN
        else if (w_wd_exp) begin
          w_state_d = StIdle;
          w_rd_d    = 1'b1;
          w_res_d   = '0;
          w_err_d   = 1'b1;
        end
`endif
      end
      StBGo: w_state_d = StBWait;
      StBWait: begin
        if (w_br_rd) begin
          w_res_d   = w_br_res;
          w_rd_d    = 1'b1;
          w_state_d = StIdle;
        end
`ifdef IF_DISPATCH_TIMEOUT_EN
        else if (w_wd_exp) begin
          w_state_d = StIdle;
          w_rd_d    = 1'b1;
          w_res_d   = '0;
          w_err_d   = 1'b1;
        end
`endif
      end
      default: begin
        w_state_d = StIdle;
        w_rd_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= StIdle;
      r_rd    <= 1'b1;
      r_res   <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_op3   <= '0;
      r_sel   <= 1'b0;
      r_p_st  <= 1'b0;
      r_y_st  <= 1'b0;
      r_n_st  <= 1'b0;
`ifdef IF_DISPATCH_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_rd    <= w_rd_d;
      r_res   <= w_res_d;
      r_op1   <= w_op1_d;
      r_op2   <= w_op2_d;
      r_op3   <= w_op3_d;
      r_sel   <= w_sel_d;
      r_p_st  <= w_p_st_d;
      r_y_st  <= w_y_st_d;
      r_n_st  <= w_n_st_d;
`ifdef IF_DISPATCH_TIMEOUT_EN
      r_err   <= w_err_d;
`endif
    end
  end

  assign RD   = r_rd;
  assign RES  = r_res;
  assign OP1  = r_op1;
  assign OP2  = r_op2;
  assign OP3  = r_op3;
  assign P_ST = r_p_st;
  assign Y_ST = r_y_st;
  assign N_ST = r_n_st;

endmodule

// File: tb/tb_if_dispatch.sv
// Bench for if_dispatch: mock sub-blocks with programmable latency, table and random checks.
module tb_if_dispatch;

  localparam int W = 16;

  logic         CLK, RST, ST, RD, P_ST, P_RD, Y_ST, Y_RD, N_ST, N_RD;
  logic [W-1:0] RES, IN1, IN2, IN3, OP1, OP2, OP3, P_RES, Y_RES, N_RES;
`ifdef IF_DISPATCH_TIMEOUT_EN
  logic         ERR;
`endif

  int           total = 0;
  int           bad = 0;
  int           lat_p = 5, lat_b = 5;
  logic [W-1:0] p_val = '0, y_val = '0, n_val = '0;
  bit           y_stuck = 0;
  int           p_cnt, y_cnt, n_cnt;

`ifdef IF_DISPATCH_TIMEOUT_EN
  if_dispatch #(.WIDTH(W), .TMO(20)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .RD(RD), .RES(RES), .ERR(ERR),
`else
  if_dispatch #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .RD(RD), .RES(RES),
`endif
    .IN1(IN1), .IN2(IN2), .IN3(IN3), .OP1(OP1), .OP2(OP2), .OP3(OP3),
    .P_ST(P_ST), .P_RD(P_RD), .P_RES(P_RES),
    .Y_ST(Y_ST), .Y_RD(Y_RD), .Y_RES(Y_RES),
    .N_ST(N_ST), .N_RD(N_RD), .N_RES(N_RES)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // Mock blocks: drop RD the edge after ST, drive junk while busy, finish after the latency.
  always @(posedge CLK) begin
    if (!RST) begin
      P_RD <= 1; P_RES <= '0; p_cnt <= 0;
    end else if (P_ST) begin
      P_RD <= 0; P_RES <= ~p_val; p_cnt <= lat_p;
    end else if (p_cnt > 1) p_cnt <= p_cnt - 1;
    else if (p_cnt == 1) begin
      P_RD <= 1; P_RES <= p_val; p_cnt <= 0;
    end
  end

  always @(posedge CLK) begin
    if (!RST) begin
      Y_RD <= 1; Y_RES <= '0; y_cnt <= 0;
    end else if (Y_ST) begin
      Y_RD <= 0; Y_RES <= ~y_val; y_cnt <= lat_b;
    end else if (y_cnt > 1) y_cnt <= y_cnt - 1;
    else if (y_cnt == 1 && !y_stuck) begin
      Y_RD <= 1; Y_RES <= y_val; y_cnt <= 0;
    end
  end

  always @(posedge CLK) begin
    if (!RST) begin
      N_RD <= 1; N_RES <= '0; n_cnt <= 0;
    end else if (N_ST) begin
      N_RD <= 0; N_RES <= ~n_val; n_cnt <= lat_b;
    end else if (n_cnt > 1) n_cnt <= n_cnt - 1;
    else if (n_cnt == 1) begin
      N_RD <= 1; N_RES <= n_val; n_cnt <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One operation; counts busy cycles, start pulses and operand disturbances.
  task automatic run_op(input logic [W-1:0] a, b, c, input int inject,
                        output int low, output int pst, output int yst, output int nst,
                        output int opbad, output bit tmo);
    bit done;
    @(negedge CLK);
    IN1 = a; IN2 = b; IN3 = c; ST = 1;
    @(negedge CLK);
    ST = 0;
    low = 0; pst = 0; yst = 0; nst = 0; opbad = 0; done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (RD) done = 1;
      else begin
        low++;
        pst += int'(P_ST); yst += int'(Y_ST); nst += int'(N_ST);
        if (OP1 !== a || OP2 !== b || OP3 !== c) opbad++;
        if (k == inject) begin
          IN1 = 9; IN2 = 9; IN3 = 9; ST = 1;
        end else if (k == inject + 1) ST = 0;
        @(negedge CLK);
      end
    end
    ST = 0;
    tmo = !done;
  endtask

  task automatic wait_rd(input logic v, output bit ok);
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge CLK);
      if (RD === v) ok = 1;
    end
  endtask

  typedef struct {
    logic [W-1:0] a, b, c, pv, yv, nv;
    int lp, lb, inject;
    logic [W-1:0] exp_res;
    int exp_low, exp_y, exp_n;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int low, pst, yst, nst, opbad;
    bit tmo, ok;
    logic [W-1:0] a, b, c, exp_res;

    vecs[0] = '{1, 2, 3, 1, 2, 3, 5, 5, -1, 2, 14, 1, 0};
    vecs[1] = '{1, 2, 3, 0, 2, 3, 5, 5, -1, 3, 14, 0, 1};
    vecs[2] = '{1, 2, 3, 1, 2, 3, 5, 5, 5, 2, 14, 1, 0};
    vecs[3] = '{16'h00FF, 16'h1234, 16'hFFFF, 16'h8000, 16'hFFFF, 0, 1, 1, -1, 16'hFFFF, 6, 1, 0};
    vecs[4] = '{7, 8, 9, 0, 16'hAAAA, 0, 3, 8, -1, 0, 15, 0, 1};

    RST = 0; ST = 0; IN1 = '0; IN2 = '0; IN3 = '0;
    repeat (3) @(negedge CLK);
    chk("reset RD", RD, 1);
    chk("reset RES", RES, 0);
    chk("reset OP", {OP1, OP2, OP3}, 0);
    chk("reset ST outs", {P_ST, Y_ST, N_ST}, 0);
`ifdef IF_DISPATCH_TIMEOUT_EN
    chk("reset ERR", ERR, 0);
`endif
    RST = 1;

    foreach (vecs[i]) begin
      p_val = vecs[i].pv; y_val = vecs[i].yv; n_val = vecs[i].nv;
      lat_p = vecs[i].lp; lat_b = vecs[i].lb;
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].inject, low, pst, yst, nst, opbad, tmo);
      chk($sformatf("vec%0d timeout", i), tmo, 0);
      chk($sformatf("vec%0d RES", i), RES, vecs[i].exp_res);
      chk($sformatf("vec%0d busy cycles", i), low, vecs[i].exp_low);
      chk($sformatf("vec%0d P_ST pulses", i), pst, 1);
      chk($sformatf("vec%0d Y_ST pulses", i), yst, vecs[i].exp_y);
      chk($sformatf("vec%0d N_ST pulses", i), nst, vecs[i].exp_n);
      chk($sformatf("vec%0d operands", i), opbad, 0);
    end

    for (int i = 0; i < 25; i++) begin
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      p_val = ($urandom_range(0, 1) == 1) ? W'($urandom_range(1, 65535)) : '0;
      y_val = W'($urandom); n_val = W'($urandom);
      lat_p = $urandom_range(1, 8); lat_b = $urandom_range(1, 8);
      exp_res = (p_val != 0) ? y_val : n_val;
      run_op(a, b, c, -1, low, pst, yst, nst, opbad, tmo);
      chk($sformatf("rnd%0d RES", i), RES, exp_res);
      chk($sformatf("rnd%0d busy cycles", i), low, 4 + lat_p + lat_b);
      chk($sformatf("rnd%0d branch starts", i), {pst, yst, nst},
          {32'd1, (p_val != 0) ? 32'd1 : 32'd0, (p_val != 0) ? 32'd0 : 32'd1});
      chk($sformatf("rnd%0d operands", i), opbad + int'(tmo), 0);
    end

    // ST held high across two operations.
    lat_p = 2; lat_b = 3; p_val = 1; y_val = 16'h1111; n_val = 16'h2222;
    @(negedge CLK);
    IN1 = 1; IN2 = 2; IN3 = 3; ST = 1;
    wait_rd(0, ok); chk("b2b first accept", ok, 1);
    wait_rd(1, ok); chk("b2b first done", ok, 1);
    chk("b2b first RES", RES, 16'h1111);
    p_val = 0; IN1 = 4; IN2 = 5; IN3 = 6;
    @(negedge CLK);
    chk("b2b RD one cycle", RD, 0);
    chk("b2b new operands", {OP1, OP2, OP3}, {16'd4, 16'd5, 16'd6});
    ST = 0;
    wait_rd(1, ok); chk("b2b second done", ok, 1);
    chk("b2b second RES", RES, 16'h2222);

    // Reset while waiting on the branch.
    lat_p = 3; lat_b = 6; p_val = 5; y_val = 16'h0BEE;
    @(negedge CLK);
    IN1 = 1; IN2 = 2; IN3 = 3; ST = 1;
    @(negedge CLK);
    ST = 0;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge CLK);
      if (Y_ST) ok = 1;
    end
    chk("mid reset reached branch", ok, 1);
    repeat (2) @(negedge CLK);
    chk("mid reset busy before", RD, 0);
    RST = 0;
    @(negedge CLK);
    chk("mid reset RD", RD, 1);
    chk("mid reset RES", RES, 0);
    chk("mid reset ST outs", {P_ST, Y_ST, N_ST}, 0);
    chk("mid reset OP", {OP1, OP2, OP3}, 0);
    RST = 1;
    lat_p = 2; lat_b = 2;
    run_op(11, 12, 13, -1, low, pst, yst, nst, opbad, tmo);
    chk("post reset RES", RES, 16'h0BEE);
    chk("post reset busy cycles", low, 8);

`ifdef IF_DISPATCH_TIMEOUT_EN
    lat_p = 3; lat_b = 2; p_val = 1; y_stuck = 1;
    run_op(1, 2, 3, -1, low, pst, yst, nst, opbad, tmo);
    chk("tmo ended", tmo, 0);
    chk("tmo busy cycles", low, 3 + 3 + 20);
    chk("tmo ERR", ERR, 1);
    chk("tmo RES", RES, 0);
    RST = 0;
    @(negedge CLK);
    RST = 1;
    y_stuck = 0;
    @(negedge CLK);
    IN1 = 1; IN2 = 2; IN3 = 3; ST = 1;
    @(negedge CLK);
    ST = 0;
    chk("tmo ERR cleared", ERR, 0);
    wait_rd(1, ok); chk("tmo recovery done", ok, 1);
    chk("tmo recovery RES", RES, y_val);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
